// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central hazard/stall controller for a five-stage pipeline. Decides each
//   cycle whether the pipeline advances one stage. When it advances, it also
//   decides which stage registers take a bubble. It owns the data-memory
//   handshake and the halt state, and counts stall cycles.
//
// Ports
//   CLK, RST        clock (rising edge) and synchronous active-high reset
//   ihit, dhit      instruction fetch / data access completed this cycle
//   mem_dREN/WEN    load / store sitting in the MEM stage
//   load_use        ID instruction needs the result of the load in EX
//   branch_taken    branch/jump resolved taken in MEM
//   halt_in         halt instruction in MEM
//   *_en            stage register enables (pc, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   *_flush         stage register flushes (bubble insert)
//   dmem_req        data memory request valid
//   halt_out        processor halted
//   stall_cnt       saturating count of non-advancing cycles
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        halt_in,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        dmem_req,
    output logic        halt_out,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,   // waiting for the data access to complete
        DDONE = 2'd2,   // data access done, still waiting on the fetch
        HALT  = 2'd3
    } state_t;

    state_t      stateReg;
    state_t      stateNext;
    logic        advance;
    logic        memOp;
    logic [15:0] stallCntReg;

    assign memOp = mem_dREN | mem_dWEN;

    // State and stall counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg    <= RUN;
            stallCntReg <= 16'h0000;
        end else begin
            stateReg <= stateNext;
            // HALT freezes the counter. Otherwise every non-advancing cycle
            // counts, and the count sticks at all-ones.
            if (stateReg != HALT && !advance && stallCntReg != 16'hFFFF)
                stallCntReg <= stallCntReg + 16'd1;
        end
    end

    // Next-state and advance decision.
    always_comb begin
        stateNext = stateReg;
        advance   = 1'b0;
        unique case (stateReg)
            RUN: begin
                if (halt_in) begin
                    stateNext = HALT;
                end else if (!memOp) begin
                    advance = ihit;
                end else if (dhit && ihit) begin
                    advance = 1'b1;
                end else if (dhit) begin
                    stateNext = DDONE;
                end else begin
                    stateNext = DWAIT;
                end
            end
            DWAIT: begin
                if (dhit && ihit) begin
                    advance   = 1'b1;
                    stateNext = RUN;
                end else if (dhit) begin
                    stateNext = DDONE;
                end
            end
            DDONE: begin
                // The data result is already captured, so dhit no longer matters.
                if (ihit) begin
                    advance   = 1'b1;
                    stateNext = RUN;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // Outputs: purely combinational from state and inputs, all held low in reset.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dmem_req    = 1'b0;
        halt_out    = 1'b0;
        if (!RST) begin
            if (advance) begin
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (branch_taken) begin
                    // A taken branch squashes the wrong-path instructions,
                    // so any load-use stall is moot.
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID and push a bubble into EX.
                    idex_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            dmem_req = ((stateReg == RUN) && memOp && !halt_in) ||
                       (stateReg == DWAIT);
            halt_out = (stateReg == HALT);
        end
    end

    assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed-vector bench for pipeline_ctrl. Inputs change 1 ns after a
//   rising edge. Combinational outputs are sampled 2 ns after that, well
//   before the next edge. Expected values are hand-derived constants.
module tb_pipeline_ctrl;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, load_use, branch_taken, halt_in;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        dmem_req, halt_out;
    logic [15:0] stall_cnt;

    int testCount = 0;
    int failCount = 0;

    pipeline_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .mem_dREN     (mem_dREN),
        .mem_dWEN     (mem_dWEN),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .halt_in      (halt_in),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .dmem_req     (dmem_req),
        .halt_out     (halt_out),
        .stall_cnt    (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bundles in port order: {pc, ifid, idex, exmem, memwb} and {ifid, idex, exmem}.
    wire [4:0] enVec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [2:0] flVec = {ifid_flush, idex_flush, exmem_flush};

    task automatic checkEq(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Drive inputs; they take effect before the next rising edge.
    task automatic setIn(input logic ih, input logic dh, input logic rd, input logic wr,
                         input logic lu, input logic bt, input logic hl);
        ihit = ih; dhit = dh; mem_dREN = rd; mem_dWEN = wr;
        load_use = lu; branch_taken = bt; halt_in = hl;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0);
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset holds every output low, even with all inputs active.
        setIn(1, 1, 1, 1, 1, 1, 1);
        checkEq("rst_en", {27'd0, enVec}, 32'h0);
        checkEq("rst_flush", {29'd0, flVec}, 32'h0);
        checkEq("rst_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("rst_halt_out", {31'd0, halt_out}, 32'h0);
        tick();
        RST = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0);
        checkEq("rst_stall_cnt", {16'd0, stall_cnt}, 32'h0);

        // Free-running: ihit every cycle, no hazards.
        for (int i = 0; i < 10; i++) begin
            setIn(1, 0, 0, 0, 0, 0, 0);
            checkEq($sformatf("run%0d_en", i), {27'd0, enVec}, 32'h1F);
            checkEq($sformatf("run%0d_flush", i), {29'd0, flVec}, 32'h0);
            tick();
        end
        checkEq("run_stall_cnt", {16'd0, stall_cnt}, 32'h0);

        // Load waits 3 cycles for dhit, then dhit and ihit together.
        doReset();
        for (int i = 0; i < 3; i++) begin
            setIn(1, 0, 1, 0, 0, 0, 0);
            checkEq($sformatf("ld%0d_dmem_req", i), {31'd0, dmem_req}, 32'h1);
            checkEq($sformatf("ld%0d_en", i), {27'd0, enVec}, 32'h0);
            tick();
        end
        setIn(1, 1, 1, 0, 0, 0, 0);
        checkEq("ld3_dmem_req", {31'd0, dmem_req}, 32'h1);
        checkEq("ld3_en", {27'd0, enVec}, 32'h1F);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checkEq("ld_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        checkEq("ld_back_run_dmem_req", {31'd0, dmem_req}, 32'h0);

        // Store: dhit without ihit goes to DDONE, and ihit arrives 2 cycles later.
        doReset();
        setIn(0, 1, 0, 1, 0, 0, 0);
        checkEq("st0_dmem_req", {31'd0, dmem_req}, 32'h1);
        checkEq("st0_en", {27'd0, enVec}, 32'h0);
        tick();
        setIn(0, 0, 0, 1, 0, 0, 0);
        checkEq("st1_ddone_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("st1_en", {27'd0, enVec}, 32'h0);
        tick();
        setIn(1, 0, 0, 1, 0, 0, 0);
        checkEq("st2_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("st2_en", {27'd0, enVec}, 32'h1F);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checkEq("st_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // DWAIT, then dhit without ihit moves on to DDONE.
        doReset();
        setIn(0, 0, 1, 0, 0, 0, 0);
        tick();
        setIn(0, 1, 1, 0, 0, 0, 0);
        checkEq("dw_dhit_dmem_req", {31'd0, dmem_req}, 32'h1);
        checkEq("dw_dhit_en", {27'd0, enVec}, 32'h0);
        tick();
        setIn(0, 0, 1, 0, 0, 0, 0);
        checkEq("dw_to_ddone_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("dw_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // Hazards on advancing cycles.
        doReset();
        setIn(1, 0, 0, 0, 1, 1, 0);
        checkEq("lu_bt_en", {27'd0, enVec}, 32'h1F);
        checkEq("lu_bt_flush", {29'd0, flVec}, 32'h7);
        tick();
        setIn(1, 0, 0, 0, 1, 0, 0);
        checkEq("lu_en", {27'd0, enVec}, 32'h07);
        checkEq("lu_flush", {29'd0, flVec}, 32'h2);
        tick();
        setIn(1, 0, 0, 0, 0, 1, 0);
        checkEq("bt_en", {27'd0, enVec}, 32'h1F);
        checkEq("bt_flush", {29'd0, flVec}, 32'h7);
        tick();
        setIn(0, 0, 0, 0, 1, 1, 0);
        checkEq("hz_noadv_en", {27'd0, enVec}, 32'h0);
        checkEq("hz_noadv_flush", {29'd0, flVec}, 32'h0);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0);
        checkEq("hz_stall_cnt", {16'd0, stall_cnt}, 32'd1);

        // Halt takes priority, HALT is absorbing, and reset is the only way out.
        doReset();
        setIn(1, 1, 1, 0, 0, 0, 1);
        checkEq("hl0_en", {27'd0, enVec}, 32'h0);
        checkEq("hl0_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("hl0_halt_out", {31'd0, halt_out}, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            setIn(1, 1, 1, 0, 1, 1, 0);
            checkEq($sformatf("hl%0d_halt_out", i + 1), {31'd0, halt_out}, 32'h1);
            checkEq($sformatf("hl%0d_en", i + 1), {27'd0, enVec}, 32'h0);
            checkEq($sformatf("hl%0d_dmem_req", i + 1), {31'd0, dmem_req}, 32'h0);
            checkEq($sformatf("hl%0d_stall_cnt", i + 1), {16'd0, stall_cnt}, 32'd1);
            tick();
        end
        RST = 1'b1;
        setIn(1, 0, 0, 0, 0, 0, 0);
        checkEq("hl_rst_halt_out", {31'd0, halt_out}, 32'h0);
        tick();
        RST = 1'b0;
        setIn(1, 0, 0, 0, 0, 0, 0);
        checkEq("hl_post_halt_out", {31'd0, halt_out}, 32'h0);
        checkEq("hl_post_stall_cnt", {16'd0, stall_cnt}, 32'h0);
        checkEq("hl_post_en", {27'd0, enVec}, 32'h1F);

        // Reset while in DWAIT returns to RUN, so dmem_req then follows memop only.
        doReset();
        setIn(1, 0, 1, 0, 0, 0, 0);
        tick();
        RST = 1'b1;
        setIn(1, 0, 1, 0, 0, 0, 0);
        checkEq("dwrst_dmem_req", {31'd0, dmem_req}, 32'h0);
        tick();
        RST = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0);
        checkEq("dwrst_nomem_dmem_req", {31'd0, dmem_req}, 32'h0);
        checkEq("dwrst_stall_cnt", {16'd0, stall_cnt}, 32'h0);
        setIn(1, 1, 1, 0, 0, 0, 0);
        checkEq("dwrst_mem_dmem_req", {31'd0, dmem_req}, 32'h1);
        checkEq("dwrst_mem_en", {27'd0, enVec}, 32'h1F);

        // Saturation after 65535+ stall cycles.
        doReset();
        setIn(0, 0, 0, 0, 0, 0, 0);
        repeat (65534) tick();
        checkEq("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
        tick();
        checkEq("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
        repeat (3) tick();
        checkEq("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
